// File: rtl/npu_pkg.sv
// Shared NPU definitions: controller state encoding and default fixed-point format.
package npu_pkg;

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } mac_state_t;

  localparam int NPU_NBITS = 8;
  localparam int NPU_DBITS = 4;

endpackage

// File: rtl/mac_controller_multiplier.sv
// Fixed-point multiplier: Q(NBITS-DBITS).DBITS x Q(NBITS-DBITS).DBITS -> same format.
// The result is rescaled by an arithmetic right shift, so it truncates toward
// -infinity, and any overflow wraps.
module Multiplier #(
  parameter int NBITS = 8,
  parameter int DBITS = 4
) (
  input  logic [NBITS-1:0] a,
  input  logic [NBITS-1:0] b,
  output logic [NBITS-1:0] p
);

  localparam int WW = NBITS + DBITS;

  logic signed [WW-1:0] a_ext;
  logic signed [WW-1:0] b_ext;
  logic signed [WW-1:0] prod_full;

  // Sign-extend both operands, keep the low WW bits of the product, drop DBITS fraction bits
  always_comb begin
    a_ext     = {{DBITS{a[NBITS-1]}}, a};
    b_ext     = {{DBITS{b[NBITS-1]}}, b};
    prod_full = a_ext * b_ext;
    p         = NBITS'(prod_full >>> DBITS);
  end

endmodule

// File: rtl/mac_controller.sv
// Dot-product sequencer: accepts LEN operand pairs, multiplies each on the shared
// Multiplier, accumulates with wraparound, and returns one optionally ReLU'd result.
module mac_controller
  import npu_pkg::*;
#(
  parameter int NBITS = NPU_NBITS,
  parameter int DBITS = NPU_DBITS,
  parameter int LEN   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_val,
  output logic             req_rdy,
  input  logic [NBITS-1:0] req_a,
  input  logic [NBITS-1:0] req_b,
  input  logic             req_relu,
  output logic             resp_val,
  input  logic             resp_rdy,
  output logic [NBITS-1:0] resp_data
);

  localparam int CW = (LEN > 2) ? $clog2(LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  mac_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NBITS-1:0] acc_q, acc_d;
  logic             relu_q, relu_d;
  logic [NBITS-1:0] resp_data_q, resp_data_d;

  logic [NBITS-1:0] prod;
  logic [NBITS-1:0] acc_sum;
  logic             req_fire;

  Multiplier #(
    .NBITS(NBITS),
    .DBITS(DBITS)
  ) u_mult (
    .a(req_a),
    .b(req_b),
    .p(prod)
  );

  // Next-state, datapath updates and handshake outputs; req_rdy depends only on state
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    relu_d      = relu_q;
    resp_data_d = resp_data_q;
    req_rdy     = 1'b0;
    resp_val    = 1'b0;
    req_fire    = 1'b0;
    acc_sum     = (cnt_q == '0) ? prod : acc_q + prod;

    case (state_q)
      ACC: begin
        req_rdy  = 1'b1;
        req_fire = req_val;
        if (req_fire) begin
          acc_d = acc_sum;
          if (cnt_q == '0) begin
            relu_d = req_relu;
          end
          if (cnt_q == LAST) begin
            // LEN >= 2 means relu_q was already loaded on an earlier pair
            state_d     = DONE;
            cnt_d       = '0;
            resp_data_d = (relu_q && acc_sum[NBITS-1]) ? '0 : acc_sum;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        resp_val = 1'b1;
        if (resp_rdy) begin
          state_d = ACC;
        end
      end
      default: begin
        state_d = ACC;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial sum or pending result
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACC;
      cnt_q       <= '0;
      acc_q       <= '0;
      relu_q      <= 1'b0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      relu_q      <= relu_d;
      resp_data_q <= resp_data_d;
    end
  end

  assign resp_data = resp_data_q;

endmodule

// File: tb/tb_mac_controller.sv
// Directed bench for mac_controller (NBITS=8, DBITS=4, LEN=4; 1.0 = 0x10).
module tb_mac_controller;

  logic       clk;
  logic       rst;
  logic       req_val;
  logic       req_rdy;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic       req_relu;
  logic       resp_val;
  logic       resp_rdy;
  logic [7:0] resp_data;

  int total;
  int bad;

  typedef struct {
    string      name;
    logic [7:0] a;
    logic [7:0] b;
    logic       relu;
    bit         gap;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[8];

  mac_controller #(
    .NBITS(8),
    .DBITS(4),
    .LEN(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_val(req_val),
    .req_rdy(req_rdy),
    .req_a(req_a),
    .req_b(req_b),
    .req_relu(req_relu),
    .resp_val(resp_val),
    .resp_rdy(resp_rdy),
    .resp_data(resp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Feed four identical pairs; relu is offered only on the first, inverted afterwards.
  // Optional gap inserts two idle cycles with garbage operands after the second pair.
  // Returns at the cycle after the final fire (controller should be in DONE).
  task automatic run_vec(input string nm, input logic [7:0] a, input logic [7:0] b,
                         input logic relu, input bit gap, input logic [7:0] exp);
    for (int i = 0; i < 4; i++) begin
      if (gap && i == 2) begin
        req_val  = 1'b0;
        req_a    = 8'($urandom);
        req_b    = 8'($urandom);
        req_relu = ~relu;
        tick();
        tick();
        chk({nm, "_gap_val"}, 32'(resp_val), 32'd0);
      end
      chk({nm, "_rdy"}, 32'(req_rdy), 32'd1);
      req_val  = 1'b1;
      req_a    = a;
      req_b    = b;
      req_relu = (i == 0) ? relu : ~relu;
      tick();
    end
    req_val = 1'b0;
    req_a   = 8'($urandom);
    req_b   = 8'($urandom);
    chk({nm, "_resp_val"}, 32'(resp_val), 32'd1);
    chk({nm, "_data"}, 32'(resp_data), 32'(exp));
    chk({nm, "_rdy_done"}, 32'(req_rdy), 32'd0);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    req_val  = 1'b0;
    req_a    = 8'h00;
    req_b    = 8'h00;
    req_relu = 1'b0;
    resp_rdy = 1'b1;

    vecs[0] = '{"pos",      8'h10, 8'h10, 1'b0, 1'b0, 8'h40};
    vecs[1] = '{"neg",      8'hF0, 8'h20, 1'b0, 1'b0, 8'h80};
    vecs[2] = '{"neg_relu", 8'hF0, 8'h20, 1'b1, 1'b0, 8'h00};
    vecs[3] = '{"trunc_m1", 8'hFF, 8'h01, 1'b0, 1'b0, 8'hFC};
    vecs[4] = '{"trunc_p",  8'h01, 8'h01, 1'b0, 1'b0, 8'h00};
    vecs[5] = '{"wrap",     8'h70, 8'h20, 1'b0, 1'b0, 8'h80};
    vecs[6] = '{"pos_relu", 8'h10, 8'h10, 1'b1, 1'b0, 8'h40};
    vecs[7] = '{"pos_gap",  8'h10, 8'h10, 1'b0, 1'b1, 8'h40};

    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("reset_rdy", 32'(req_rdy), 32'd1);
    chk("reset_val", 32'(resp_val), 32'd0);
    chk("reset_data", 32'(resp_data), 32'd0);

    // Table: back-to-back vectors with resp_rdy held high
    for (int v = 0; v < 8; v++) begin
      run_vec(vecs[v].name, vecs[v].a, vecs[v].b, vecs[v].relu, vecs[v].gap, vecs[v].exp);
      tick();
      chk({vecs[v].name, "_after_val"}, 32'(resp_val), 32'd0);
      chk({vecs[v].name, "_after_rdy"}, 32'(req_rdy), 32'd1);
    end

    // Backpressure: DONE holds, req_val pulses ignored
    resp_rdy = 1'b0;
    run_vec("bp", 8'hF0, 8'h20, 1'b0, 1'b0, 8'h80);
    for (int c = 0; c < 3; c++) begin
      req_val = 1'b1;
      req_a   = 8'h70;
      req_b   = 8'h70;
      tick();
      chk("bp_hold_val", 32'(resp_val), 32'd1);
      chk("bp_hold_data", 32'(resp_data), 32'h80);
      chk("bp_hold_rdy", 32'(req_rdy), 32'd0);
    end
    req_val  = 1'b0;
    resp_rdy = 1'b1;
    tick();
    chk("bp_release_val", 32'(resp_val), 32'd0);
    chk("bp_release_rdy", 32'(req_rdy), 32'd1);
    run_vec("bp_next", 8'h10, 8'h10, 1'b0, 1'b0, 8'h40);
    tick();

    // Reset mid-vector, with rst coinciding with a request fire
    for (int i = 0; i < 2; i++) begin
      req_val = 1'b1;
      req_a   = 8'h70;
      req_b   = 8'h20;
      tick();
    end
    rst = 1'b1;
    tick();
    rst     = 1'b0;
    req_val = 1'b0;
    chk("rst_mid_rdy", 32'(req_rdy), 32'd1);
    chk("rst_mid_val", 32'(resp_val), 32'd0);
    run_vec("rst_mid_fresh", 8'h10, 8'h10, 1'b0, 1'b0, 8'h40);

    // Reset during DONE under backpressure
    resp_rdy = 1'b0;
    tick();
    chk("pre_rst_done_val", 32'(resp_val), 32'd1);
    rst      = 1'b1;
    resp_rdy = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_done_val", 32'(resp_val), 32'd0);
    chk("rst_done_data", 32'(resp_data), 32'd0);
    chk("rst_done_rdy", 32'(req_rdy), 32'd1);
    run_vec("rst_done_fresh", 8'hFF, 8'h01, 1'b0, 1'b0, 8'hFC);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
